// File: rtl/digital_capture_engine.sv
// Logic-analyser capture: 8 synchronised channels, programmable sample tick and trigger, 128 samples packed into a 32x32 RAM.
// Status outputs and read data are registered (1-cycle read latency); no backpressure, a held capture is released by capture_ack.
module digital_capture_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        capture_start,
  input  logic        capture_ack,
  output logic        capture_ready,
  output logic        capture_busy,
  input  logic [7:0]  digital_in,
  input  logic [15:0] sample_div,
  input  logic [1:0]  trig_mode,
  input  logic [4:0]  capture_bram_raddr,
  output logic [31:0] capture_bram_rdata
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  sync_q [SYNC_STAGES];
  logic [7:0]  din_s;
  logic        start_q, start_rise;
  logic [15:0] div_lat, div_cnt, div_last;
  logic [1:0]  mode_lat;
  logic [6:0]  idx;
  logic [7:0]  prev_sample;
  logic        prev_vld;
  logic [23:0] shadow;
  logic [31:0] mem [32];
  logic        tick, trig_hit, arm_load, store_en, mem_we;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      start_q <= 1'b0;
    end else begin
      sync_q[0] <= digital_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      start_q <= capture_start;
    end
  end

  assign din_s      = sync_q[SYNC_STAGES-1];
  assign start_rise = capture_start & ~start_q;
  // A latched divider of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign div_last   = (div_lat == 16'd0) ? 16'd0 : div_lat - 16'd1;
  assign tick       = (div_cnt == div_last);

  always_comb begin
    trig_hit = 1'b0;
    case (mode_lat)
      2'b00:   trig_hit = 1'b1;
      2'b01:   trig_hit = prev_vld & ~prev_sample[0] & din_s[0];
      2'b10:   trig_hit = prev_vld & prev_sample[0] & ~din_s[0];
      default: trig_hit = prev_vld & (prev_sample != din_s);
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arm_load  = 1'b0;
    store_en  = 1'b0;
    case (state)
      IDLE: if (start_rise) state_nxt = ARM;
      ARM: begin
        arm_load  = 1'b1;
        state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (!capture_start) begin
          state_nxt = IDLE;
        end else if (tick && trig_hit) begin
          store_en  = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (tick) begin
          store_en = 1'b1;
          if (idx == 7'd127) state_nxt = DONE;
        end
      end
      DONE: if (capture_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane 3 completes a word; reset suppresses any write in flight.
  assign mem_we = store_en & (idx[1:0] == 2'b11) & ~HRESET;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div_lat       <= '0;
      mode_lat      <= '0;
      div_cnt       <= '0;
      idx           <= '0;
      prev_sample   <= '0;
      prev_vld      <= 1'b0;
      shadow        <= '0;
      capture_busy  <= 1'b0;
      capture_ready <= 1'b0;
    end else begin
      capture_busy  <= (state_nxt == ARM) || (state_nxt == WAIT_TRIG) || (state_nxt == CAPTURE);
      capture_ready <= (state_nxt == DONE);
      if (arm_load) begin
        div_lat  <= sample_div;
        mode_lat <= trig_mode;
        div_cnt  <= '0;
        idx      <= '0;
        prev_vld <= 1'b0;
      end else if (state == WAIT_TRIG || state == CAPTURE) begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
        if (tick && state == WAIT_TRIG) begin
          prev_sample <= din_s;
          prev_vld    <= 1'b1;
        end
      end
      if (store_en) begin
        idx <= idx + 7'd1;
        case (idx[1:0])
          2'b00:   shadow[7:0]   <= din_s;
          2'b01:   shadow[15:8]  <= din_s;
          2'b10:   shadow[23:16] <= din_s;
          default: begin end
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) mem[idx[6:2]] <= {din_s, shadow};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) capture_bram_rdata <= '0;
    else        capture_bram_rdata <= mem[capture_bram_raddr];
  end

endmodule

// File: tb/tb_digital_capture_engine.sv
// Randomised bench for digital_capture_engine: a tick/trigger timing model predicts captured words and
// ready timing; a negedge monitor pops the expectation queues whenever read data or capture_ready appears.
module tb_digital_capture_engine;
  localparam int SYNC = 2;
  localparam int HIST = 8192;

  logic        clk = 1'b0, rst = 1'b1, cap_start = 1'b0, cap_ack = 1'b0;
  logic        ready, busy;
  logic [7:0]  din = 8'd0;
  logic [15:0] sdiv = 16'd1;
  logic [1:0]  tmode = 2'd0;
  logic [4:0]  raddr = 5'd0;
  logic [31:0] rdata;

  int checks = 0, failures = 0;
  int edge_n = 0;
  logic [7:0]  din_hist [HIST];
  logic [31:0] exp_mem [32];
  logic [7:0]  cap_s [128];
  int trig_k, last_edge;
  logic [31:0] rd_q [$];
  int          rdtag_q [$];
  int          rdy_q [$];
  logic rd_vld = 1'b0, rd_pend = 1'b0, ready_prev = 1'b0;

  digital_capture_engine #(.SYNC_STAGES(SYNC)) dut (
    .HCLK(clk), .HRESET(rst), .capture_start(cap_start), .capture_ack(cap_ack),
    .capture_ready(ready), .capture_busy(busy), .digital_in(din), .sample_div(sdiv),
    .trig_mode(tmode), .capture_bram_raddr(raddr), .capture_bram_rdata(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(posedge clk) rd_pend <= rd_vld;

  // Replays the pre-generated channel history: din_hist[e] is what the DUT sees at edge e.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (edge_n + 1 < HIST) din = din_hist[edge_n + 1];
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    int t, ee;
    if (rd_pend) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%h exp=<none>", rdata);
      end else begin
        e = rd_q.pop_front();
        t = rdtag_q.pop_front();
        if (rdata !== e) begin
          failures++;
          $display("FAIL rd_word%0d got=%h exp=%h", t, rdata, e);
        end
      end
    end
    if (ready === 1'b1 && !ready_prev) begin
      checks++;
      if (rdy_q.size() == 0) begin
        failures++;
        $display("FAIL ready_unexpected at_edge=%0d exp=<none>", edge_n);
      end else begin
        ee = rdy_q.pop_front();
        if (edge_n != ee || busy !== 1'b0) begin
          failures++;
          $display("FAIL ready_edge got_edge=%0d busy=%b exp_edge=%0d busy=0", edge_n, busy, ee);
        end
      end
    end
    ready_prev = (ready === 1'b1);
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int te(input int s0, input int eff, input int k);
    return s0 + 2 + eff * (k + 1);
  endfunction

  function automatic logic [7:0] smp(input int e);
    return din_hist[e - SYNC];
  endfunction

  // Trigger search over tick samples, then the 128 captured bytes.
  task automatic predict(input int s0, input int eff, input logic [1:0] mode);
    logic [7:0] p, c;
    logic hit;
    int k;
    k = 0;
    if (mode != 2'b00) begin
      p = smp(te(s0, eff, 0));
      for (k = 1; te(s0, eff, k) < HIST - 1; k++) begin
        c = smp(te(s0, eff, k));
        case (mode)
          2'b01:   hit = !p[0] && c[0];
          2'b10:   hit = p[0] && !c[0];
          default: hit = (c != p);
        endcase
        if (hit) break;
        p = c;
      end
    end
    trig_k = k;
    for (int i = 0; i < 128; i++) cap_s[i] = smp(te(s0, eff, k + i));
    last_edge = te(s0, eff, k + 127);
  endtask

  task automatic commit_mem(input int nwords);
    for (int w = 0; w < nwords; w++)
      exp_mem[w] = {cap_s[4*w+3], cap_s[4*w+2], cap_s[4*w+1], cap_s[4*w]};
  endtask

  // pat: 0 counting, 1 random, 2 ch0 low 40 cycles then high, 3 ch0 low, 4 constant then random
  task automatic setup_capture(input int pat, input logic [1:0] mode, input logic [15:0] div, output int s0);
    int base, rel;
    logic [7:0] r;
    cap_start = 1'b0;
    tmode = mode;
    sdiv = div;
    cyc(1);
    base = edge_n + SYNC;
    for (int c = edge_n + 2; c < edge_n + 1200 && c < HIST; c++) begin
      r = 8'($urandom);
      rel = c - base;
      case (pat)
        0:       din_hist[c] = 8'(c);
        1:       din_hist[c] = r;
        2:       din_hist[c] = {r[7:1], (rel > 40) ? 1'b1 : 1'b0};
        3:       din_hist[c] = {r[7:1], 1'b0};
        default: din_hist[c] = (rel < 20) ? 8'h5A : r;
      endcase
    end
    cyc(SYNC);
    s0 = edge_n;
    cap_start = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin cyc(1); n++; end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_timeout got=%b exp=1", name, ready);
    end
  endtask

  task automatic read_word(input int w);
    raddr = w[4:0];
    rd_vld = 1'b1;
    rd_q.push_back(exp_mem[w]);
    rdtag_q.push_back(w);
    cyc(1);
    rd_vld = 1'b0;
  endtask

  task automatic ack_done(input string name);
    cap_ack = 1'b1;
    cyc(1);
    cap_ack = 1'b0;
    chk({name, "_ack_ready"}, ready, 0);
    chk({name, "_ack_busy"}, busy, 0);
  endtask

  initial begin
    int s0, target, ew;
    logic [31:0] oldw, neww;
    for (int i = 0; i < HIST; i++) din_hist[i] = 8'd0;

    cyc(3);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    cyc(4);

    // Immediate trigger, every-cycle ticks, counting channels.
    setup_capture(0, 2'b00, 16'd1, s0);
    predict(s0, 1, 2'b00);
    rdy_q.push_back(last_edge);
    cyc(3);
    chk("t1_busy", busy, 1);
    wait_ready("t1");
    commit_mem(32);
    ack_done("t1");
    for (int w = 0; w < 32; w++) read_word(w);
    cyc(2);

    // ch0 rising edge, divide by 4; a stray ack mid-capture is ignored.
    setup_capture(2, 2'b01, 16'd4, s0);
    predict(s0, 4, 2'b01);
    rdy_q.push_back(last_edge);
    cyc(60);
    cap_ack = 1'b1;
    cyc(1);
    cap_ack = 1'b0;
    chk("t2_busy_after_stray_ack", busy, 1);
    wait_ready("t2");
    commit_mem(32);
    ack_done("t2");
    for (int w = 0; w < 32; w++) read_word(w);
    cyc(2);

    // Falling-edge mode with ch0 stuck low never fires; dropping start aborts.
    setup_capture(3, 2'b10, 16'd1, s0);
    cyc(50);
    chk("t3_waiting_busy", busy, 1);
    chk("t3_waiting_ready", ready, 0);
    cap_start = 1'b0;
    cyc(3);
    chk("t3_abort_busy", busy, 0);
    chk("t3_abort_ready", ready, 0);
    for (int i = 0; i < 6; i++) read_word($urandom_range(31));
    cyc(2);

    // Any-change mode, divide by 2; start edge in DONE needs a coincident ack and then a fresh edge.
    setup_capture(4, 2'b11, 16'd2, s0);
    predict(s0, 2, 2'b11);
    rdy_q.push_back(last_edge);
    wait_ready("t4");
    commit_mem(32);
    cap_start = 1'b0;
    cyc(1);
    cap_start = 1'b1;
    cyc(2);
    chk("t4_rise_in_done_ready", ready, 1);
    chk("t4_rise_in_done_busy", busy, 0);
    cap_start = 1'b0;
    cyc(1);
    cap_start = 1'b1;
    cap_ack = 1'b1;
    cyc(1);
    cap_ack = 1'b0;
    chk("t4_ack_rise_ready", ready, 0);
    chk("t4_ack_rise_busy", busy, 0);
    cyc(6);
    chk("t4_no_restart_busy", busy, 0);
    for (int i = 0; i < 8; i++) read_word($urandom_range(31));
    cyc(2);

    // Divider 0 acts as 1; reset at sample 50 leaves words 12..31 from the previous capture.
    setup_capture(1, 2'b00, 16'd0, s0);
    predict(s0, 1, 2'b00);
    target = te(s0, 1, trig_k + 50) - 1;
    while (edge_n < target) cyc(1);
    rst = 1'b1;
    cap_start = 1'b0;
    cyc(1);
    chk("t5_rst_ready", ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdata", rdata, 0);
    rst = 1'b0;
    commit_mem(12);
    cyc(SYNC + 2);
    chk("t5_post_rst_busy", busy, 0);
    for (int w = 0; w < 32; w++) read_word(w);
    cyc(2);

    // Reading word 5 in the cycle it is written returns the old word, then the new one.
    setup_capture(1, 2'b00, 16'd3, s0);
    predict(s0, 3, 2'b00);
    rdy_q.push_back(last_edge);
    ew = te(s0, 3, trig_k + 23);
    oldw = exp_mem[5];
    neww = {cap_s[23], cap_s[22], cap_s[21], cap_s[20]};
    while (edge_n < ew - 1) cyc(1);
    raddr = 5'd5;
    rd_vld = 1'b1;
    rd_q.push_back(oldw);
    rdtag_q.push_back(5);
    cyc(1);
    rd_q.push_back(neww);
    rdtag_q.push_back(5);
    cyc(1);
    rd_vld = 1'b0;
    wait_ready("t6");
    commit_mem(32);
    ack_done("t6");
    for (int i = 0; i < 4; i++) read_word($urandom_range(31));
    cyc(3);

    if (rd_q.size() != 0 || rdy_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queues_drained got_rd=%0d got_rdy=%0d exp=0", rd_q.size(), rdy_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
